// File: rtl/a25_cache_pkg.sv
// Shared cache definitions: flush sequencer state encoding and default cache geometry.
package a25_cache_pkg;

  localparam int unsigned CACHE_WAYS    = 4;
  localparam int unsigned CACHE_INDEX_W = 8;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_SWEEP = 2'd1,
    FLUSH_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/a25_cache_flush_sequencer.sv
// Full-cache invalidate sequencer: walks every index through a valid/ready tag-RAM port.
// Optional feature macro: A25_FLUSH_ON_ENABLE_EN (cache-enable rising edge also starts a flush).
module a25_cache_flush_sequencer
  import a25_cache_pkg::*;
#(
  parameter int unsigned WAYS    = CACHE_WAYS,
  parameter int unsigned INDEX_W = CACHE_INDEX_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush_req,
  input  logic               i_cache_enable,
  output logic               o_stall,
  output logic               o_inv_valid,
  input  logic               i_inv_ready,
  output logic [INDEX_W-1:0] o_inv_index,
  output logic [WAYS-1:0]    o_inv_way_mask,
  output logic               o_flush_done
);

  localparam logic [INDEX_W-1:0] LAST_INDEX = {INDEX_W{1'b1}};

  flush_state_e       state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               pending_q, pending_d;
  logic               req_c;
  logic               beat_c;

  // Flush trigger: explicit request, optionally also a cache-enable rising edge
`ifdef A25_FLUSH_ON_ENABLE_EN
  logic enable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= i_cache_enable;
    end
  end

  assign req_c = i_flush_req | (i_cache_enable & ~enable_q);
`else
  logic unused_cache_enable;

  assign unused_cache_enable = i_cache_enable;
  assign req_c               = i_flush_req;
`endif

  assign beat_c = (state_q == FLUSH_SWEEP) & i_inv_ready;

  // State, index counter and pending flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FLUSH_IDLE;
      index_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
    end
  end

  // Next state; a request landing on the last beat folds into pending
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    pending_d = pending_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        pending_d = 1'b0;
        if (req_c) begin
          state_d = FLUSH_SWEEP;
          index_d = '0;
        end
      end
      FLUSH_SWEEP: begin
        pending_d = pending_q | req_c;
        if (beat_c) begin
          index_d = index_q + INDEX_W'(1);
          if (index_q == LAST_INDEX) begin
            index_d   = '0;
            pending_d = 1'b0;
            if (!(pending_q | req_c)) begin
              state_d = FLUSH_DONE;
            end
          end
        end
      end
      FLUSH_DONE: begin
        pending_d = 1'b0;
        index_d   = '0;
        state_d   = req_c ? FLUSH_SWEEP : FLUSH_IDLE;
      end
      default: begin
        state_d   = FLUSH_IDLE;
        index_d   = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state; stall also covers the request cycle
  always_comb begin
    o_inv_valid    = 1'b0;
    o_flush_done   = 1'b0;
    o_inv_way_mask = '0;
    o_stall        = req_c;
    if (state_q == FLUSH_SWEEP) begin
      o_inv_valid    = 1'b1;
      o_inv_way_mask = {WAYS{1'b1}};
    end
    if (state_q == FLUSH_DONE) begin
      o_flush_done = 1'b1;
    end
    if (state_q != FLUSH_IDLE) begin
      o_stall = 1'b1;
    end
  end

  assign o_inv_index = index_q;

endmodule
